param_randomizer: RTL and testbench

//  Parametrised successor to the 2-bit randomizer: Galois LFSR of configurable width

---
 rtl/randomizer_pkg.sv | 20 ++
 rtl/lfsr_core.sv | 33 +++
 rtl/param_randomizer.sv | 144 ++++++++++++++
 tb/tb_param_randomizer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/randomizer_pkg.sv
// Shared types and constants for the parametrised randomizer.
package randomizer_pkg;

  // Sample assembly FSM: FILL collects bits, STALL parks a finished sample.
  typedef enum logic {
    FILL  = 1'b0,
    STALL = 1'b1
  } state_t;

  // Maximal-length Galois feedback masks for common widths.
  localparam logic [7:0]  TAPS_8  = 8'hB8;
  localparam logic [15:0] TAPS_16 = 16'hB400;
  localparam logic [31:0] TAPS_32 = 32'hA3000000;

  // Bit counter width; a 1-bit sample still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Galois LFSR register with single-step advance, runtime load and
// zero-seed guard (a zero seed would lock the register at zero forever).
module lfsr_core #(
  parameter int                LFSR_W   = 16,
  parameter logic [LFSR_W-1:0] TAPS     = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED_RST = 16'h0001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step_en,
  input  logic              load_en,
  input  logic [LFSR_W-1:0] load_value,
  output logic              out_bit
);

  logic [LFSR_W-1:0] state_q;

  // Load has priority over stepping; the outgoing bit decides whether taps apply.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    if (rst) begin
      state_q <= SEED_RST;
    end else if (load_en) begin
      state_q <= (load_value == '0) ? LFSR_W'(1) : load_value;
    end else if (step_en) begin
      state_q <= (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
    end
  end

  assign out_bit = state_q[0];

endmodule

// File: rtl/param_randomizer.sv
// Parametrised randomizer: assembles OUT_W-bit samples from a Galois LFSR,
// one bit per step, first bit becoming the MSB, and presents them through a
// valid/ready output slot with backpressure. A finished sample that finds the
// slot full is parked in the accumulator (STALL) with the LFSR frozen.
// Optional feature: define RANDOMIZER_RANGE_EN to add the i_limit port;
// samples above i_limit are then dropped and filling restarts.
module param_randomizer
  import randomizer_pkg::*;
#(
  parameter int                LFSR_W   = 16,
  parameter int                OUT_W    = 2,
  parameter logic [LFSR_W-1:0] TAPS     = LFSR_W'(TAPS_16),
  parameter logic [LFSR_W-1:0] SEED_RST = LFSR_W'(1)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_en,
  input  logic              i_seed_load,
  input  logic [LFSR_W-1:0] i_seed,
  input  logic              i_ready,
`ifdef RANDOMIZER_RANGE_EN
  input  logic [OUT_W-1:0]  i_limit,
`endif
  output logic [OUT_W-1:0]  o_r,
  output logic              o_valid,
  output logic              o_stall
);

  localparam int               CNT_W    = cnt_width(OUT_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_W - 1);

  state_t           state_q, state_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] r_d;
  logic             valid_d;

  logic             lfsr_bit;
  logic             lfsr_step;
  logic [OUT_W-1:0] sample;
  logic             slot_free;
  logic             reject;

  lfsr_core #(
    .LFSR_W   (LFSR_W),
    .TAPS     (TAPS),
    .SEED_RST (SEED_RST)
  ) u_lfsr (
    .clk        (i_clk),
    .rst        (i_reset),
    .step_en    (lfsr_step),
    .load_en    (i_seed_load),
    .load_value (i_seed),
    .out_bit    (lfsr_bit)
  );

  // Next-state, accumulator, counter and output-slot decisions.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    r_d       = o_r;
    valid_d   = o_valid;
    lfsr_step = 1'b0;

    // Accumulator with the current LFSR output bit shifted in at the LSB.
    sample    = (acc_q << 1) | OUT_W'(lfsr_bit);
    slot_free = !o_valid || i_ready;
`ifdef RANDOMIZER_RANGE_EN
    reject    = (sample > i_limit);
`else
    reject    = 1'b0;
`endif

    // A presented sample taken by the consumer empties the slot unless
    // something below reloads it on the same edge.
    if (o_valid && i_ready) begin
      valid_d = 1'b0;
    end

    if (i_seed_load) begin
      acc_d   = '0;
      cnt_d   = '0;
      valid_d = 1'b0;
      state_d = FILL;
    end else begin
      unique case (state_q)
        FILL: begin
          if (i_en) begin
            lfsr_step = 1'b1;
            if (cnt_q != CNT_LAST) begin
              acc_d = sample;
              cnt_d = cnt_q + CNT_W'(1);
            end else if (reject) begin
              acc_d = '0;
              cnt_d = '0;
            end else if (slot_free) begin
              r_d     = sample;
              valid_d = 1'b1;
              acc_d   = '0;
              cnt_d   = '0;
            end else begin
              // Park the finished sample; cnt stays at its last value.
              acc_d   = sample;
              state_d = STALL;
            end
          end
        end
        STALL: begin
          if (i_ready) begin
            r_d     = acc_q;
            valid_d = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = FILL;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  // State, accumulator, counter and output slot registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= FILL;
      acc_q   <= '0;
      cnt_q   <= '0;
      o_r     <= '0;
      o_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      o_r     <= r_d;
      o_valid <= valid_d;
    end
  end

  assign o_stall = (state_q == STALL);

endmodule

// File: tb/tb_param_randomizer.sv
// Self-checking bench for param_randomizer (LFSR_W=16, OUT_W=2).
// The reference model treats the LFSR as a bit stream: every sample the
// consumer accepts must be the next OUT_W-bit group of that stream
// (groups above the limit skipped when RANDOMIZER_RANGE_EN is defined).
module tb_param_randomizer;

  localparam int          LFSR_W = 16;
  localparam int          OUT_W  = 2;
  localparam logic [15:0] M_TAPS = 16'hB400;

  logic              i_clk = 1'b0;
  logic              i_reset;
  logic              i_en;
  logic              i_seed_load;
  logic [LFSR_W-1:0] i_seed;
  logic              i_ready;
`ifdef RANDOMIZER_RANGE_EN
  logic [OUT_W-1:0]  i_limit;
`endif
  logic [OUT_W-1:0]  o_r;
  logic              o_valid;
  logic              o_stall;

  param_randomizer #(
    .LFSR_W   (LFSR_W),
    .OUT_W    (OUT_W),
    .TAPS     (16'hB400),
    .SEED_RST (16'h0001)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_en        (i_en),
    .i_seed_load (i_seed_load),
    .i_seed      (i_seed),
    .i_ready     (i_ready),
`ifdef RANDOMIZER_RANGE_EN
    .i_limit     (i_limit),
`endif
    .o_r         (o_r),
    .o_valid     (o_valid),
    .o_stall     (o_stall)
  );

  always #5 i_clk = ~i_clk;

  int n_vec  = 0;
  int n_err  = 0;
  int n_xfer = 0;
  int hist [4];

  // Reference stream state.
  logic [15:0] m_lfsr;
  int          m_limit = 3;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] m_next(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? M_TAPS : 16'h0);
  endfunction

  task automatic m_restart(input logic [15:0] s);
    m_lfsr = (s == 16'h0) ? 16'h0001 : s;
  endtask

  // Next accepted sample of the reference stream.
  task automatic m_next_sample(output int v);
    do begin
      v = 0;
      for (int b = 0; b < OUT_W; b++) begin
        v      = v * 2 + int'(m_lfsr[0]);
        m_lfsr = m_next(m_lfsr);
      end
    end while (v > m_limit);
  endtask

  // One clock: drive at the falling edge, score any transfer on the coming
  // rising edge, and check that a held output did not move.
  task automatic step(input logic en, input logic ready, input logic load,
                      input logic [15:0] seed);
    logic             xfer;
    logic             hold;
    logic [OUT_W-1:0] held;
    int               v;
    i_en        = en;
    i_ready     = ready;
    i_seed_load = load;
    i_seed      = seed;
    xfer = o_valid && ready;
    hold = o_valid && !ready && !load;
    held = o_r;
    if (xfer) begin
      m_next_sample(v);
      check("sample", 32'(o_r), 32'(v));
      n_xfer++;
      hist[o_r]++;
    end
    if (load) m_restart(seed);
    @(posedge i_clk);
    @(negedge i_clk);
    if (hold) begin
      check("held_valid", 32'(o_valid), 32'd1);
      check("held_r", 32'(o_r), 32'(held));
    end
    i_seed_load = 1'b0;
  endtask

  task automatic reset_mid_run();
    #3;
    i_reset = 1'b1;
    #1;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_r", 32'(o_r), 32'd0);
    check("rst_stall", 32'(o_stall), 32'd0);
    check("rst_lfsr", 32'(dut.u_lfsr.state_q), 32'h0001);
    @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
    m_restart(16'h0001);
  endtask

  initial begin
    logic [15:0] exp_frozen;
    logic [15:0] seed;
    int          first_rep;
    int          zero_seen;
    int          k;

    i_reset     = 1'b1;
    i_en        = 1'b0;
    i_seed_load = 1'b0;
    i_seed      = '0;
    i_ready     = 1'b0;
`ifdef RANDOMIZER_RANGE_EN
    i_limit     = 2'd3;
`endif
    foreach (hist[i]) hist[i] = 0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
    m_restart(16'h0001);

    // Reset state.
    check("init_valid", 32'(o_valid), 32'd0);
    check("init_r", 32'(o_r), 32'd0);
    check("init_stall", 32'(o_stall), 32'd0);
    check("init_lfsr", 32'(dut.u_lfsr.state_q), 32'h0001);

    // Known sequence from seed 0x0001, first sample after OUT_W edges.
    step(1'b1, 1'b1, 1'b0, 16'h0);
    check("lat_valid_e1", 32'(o_valid), 32'd0);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    check("s0_valid", 32'(o_valid), 32'd1);
    check("s0_r", 32'(o_r), 32'h2);
    check("s0_lfsr", 32'(dut.u_lfsr.state_q), 32'h5A00);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    check("s1_gap_valid", 32'(o_valid), 32'd0);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    check("s1_valid", 32'(o_valid), 32'd1);
    check("s1_r", 32'(o_r), 32'h0);
    check("s1_lfsr", 32'(dut.u_lfsr.state_q), 32'h1680);

    // Backpressure: ten cycles with the consumer not ready.
    exp_frozen = 16'h0001;
    for (int i = 0; i < 6; i++) exp_frozen = m_next(exp_frozen);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 16'h0);
    check("bp_stall", 32'(o_stall), 32'd1);
    check("bp_r", 32'(o_r), 32'h0);
    check("bp_lfsr_frozen", 32'(dut.u_lfsr.state_q), 32'(exp_frozen));
    step(1'b1, 1'b1, 1'b0, 16'h0);
    check("bp_release_stall", 32'(o_stall), 32'd0);
    check("bp_release_valid", 32'(o_valid), 32'd1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 16'h0);

    // Zero seed falls back to 0x0001.
    step(1'b1, 1'b1, 1'b1, 16'h0000);
    check("seed0_lfsr", 32'(dut.u_lfsr.state_q), 32'h0001);
    check("seed0_valid", 32'(o_valid), 32'd0);

    // Seed load while a sample is presented drops it.
    k = 0;
    while (!o_valid && k < 50) begin
      step(1'b1, 1'b0, 1'b0, 16'h0);
      k++;
    end
    check("wait_valid", 32'(o_valid), 32'd1);
    step(1'b1, 1'b0, 1'b1, 16'hACE1);
    check("load_drop_valid", 32'(o_valid), 32'd0);
    check("load_lfsr", 32'(dut.u_lfsr.state_q), 32'hACE1);

    // Randomised enable, ready and occasional reseed.
    for (int i = 0; i < 1500; i++) begin
      seed = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 99) == 0, seed);
      if (o_stall && !o_valid) check("stall_without_valid", 32'd1, 32'd0);
    end
    check("xfers_seen", 32'(n_xfer > 200), 32'd1);

    // Asynchronous reset between edges while a sample is presented.
    k = 0;
    while (!o_valid && k < 50) begin
      step(1'b1, 1'b0, 1'b0, 16'h0);
      k++;
    end
    check("wait_valid_rst", 32'(o_valid), 32'd1);
    reset_mid_run();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 16'h0);

`ifndef RANDOMIZER_RANGE_EN
    // Full period returns to the seed and never passes through zero.
    step(1'b0, 1'b1, 1'b1, 16'hACE1);
    first_rep = 0;
    zero_seen = 0;
    for (int i = 1; i <= 65535; i++) begin
      step(1'b1, 1'b1, 1'b0, 16'h0);
      if (dut.u_lfsr.state_q == 16'hACE1 && first_rep == 0) first_rep = i;
      if (dut.u_lfsr.state_q == 16'h0000) zero_seen = 1;
    end
    check("period_len", 32'(first_rep), 32'd65535);
    check("period_no_zero", 32'(zero_seen), 32'd0);
`else
    // Range limit 2: no 3 ever delivered, 0/1/2 near one third each.
    i_limit = 2'd2;
    m_limit = 2;
    step(1'b0, 1'b0, 1'b1, 16'h0001);
    foreach (hist[i]) hist[i] = 0;
    n_xfer = 0;
    k = 0;
    while (n_xfer < 10000 && k < 40000) begin
      step(1'b1, 1'b1, 1'b0, 16'h0);
      k++;
    end
    check("range_count", 32'(n_xfer), 32'd10000);
    check("range_no3", 32'(hist[3]), 32'd0);
    for (int v = 0; v < 3; v++) begin
      if (hist[v] < 3167 || hist[v] > 3500) check($sformatf("range_bin%0d", v), 32'(hist[v]), 32'd3333);
      else check($sformatf("range_bin%0d", v), 32'd1, 32'd1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
